layer_load_sequencer: RTL
=========================

LAYER_LOAD_SEQUENCER -- requirements
Module: layer_load_sequencer

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 1: input feature-map channel count.
REQ-002 SHALL have parameter NUM_OUTPUTS, default 1: output channel count.
REQ-003 SHALL have parameter INPUT_DIM, default 5: activation map side length.
REQ-004 SHALL have parameter KERNEL_DIM, default 3: kernel side length.
REQ-005 SHALL have parameter DATA_SIZE, default 64: data word width (IEEE-754 double bit pattern).
REQ-006 SHALL have ports, clock and reset first: clk input 1 (the single clock, rising edge); rst_n input 1 (reset, asynchronous, active-low).
REQ-007 SHALL have ports: start input 1 (begin load); in_valid input 1; in_ready output 1; in_data input DATA_SIZE (streamed word).
REQ-008 SHALL have ports: want_write_weights output 1; want_write_act output 1; write_data output DATA_SIZE; in_index3, in_index2, in_index1, in_index0 output 16 each (conv-layer write address).
REQ-009 SHALL have ports: busy output 1 (load in progress); done output 1 (one-cycle completion pulse).

Function
REQ-010 SHALL implement FSM states IDLE, LOAD_W, LOAD_A, FINISH.
REQ-011 IDLE: start=1 -> LOAD_W; start ignored in all other states.
REQ-012 in_ready SHALL be 1 exactly in LOAD_W and LOAD_A; a transfer occurs on a cycle with in_valid=1 and in_ready=1.
REQ-013 LOAD_W: transfers are weights, W_TOTAL = NUM_INPUTS*NUM_OUTPUTS*KERNEL_DIM*KERNEL_DIM words, ordered kx fastest, then ky, then out, then in.
REQ-014 LOAD_W address: index3=in, index2=out, index1=ky, index0=kx.
REQ-015 LOAD_A: transfers are activations, A_TOTAL = NUM_INPUTS*INPUT_DIM*INPUT_DIM words, ordered x fastest, then y, then entry.
REQ-016 LOAD_A address: index3=0, index2=entry, index1=y, index0=x.
REQ-017 Counters SHALL advance only on transfers; each nested counter wraps to 0 at its limit and carries into the next; in_valid without transfer changes nothing.
REQ-018 Transfer of weight W_TOTAL-1 -> LOAD_A on the next edge; transfer of activation A_TOTAL-1 -> FINISH on the next edge; all counters reset to 0 at each phase change.
REQ-019 Write outputs SHALL be registered: a transfer at edge N drives want_write_* =1, write_data=in_data, indices=that word's address for exactly the cycle after edge N; latency 1 cycle.
REQ-020 want_write_weights and want_write_act SHALL never be 1 simultaneously; both 0 on cycles with no preceding transfer.
REQ-021 Back-to-back transfers SHALL produce back-to-back write strobes, one per cycle, no bubbles.
REQ-022 FINISH: lasts one cycle, done=1 during it (coincides with the last activation write strobe), then -> IDLE.
REQ-023 busy SHALL be 1 in LOAD_W, LOAD_A, FINISH; 0 in IDLE.
REQ-024 Index outputs SHALL hold their last value when no write strobe is active.
REQ-025 Counter values SHALL be zero-extended to 16 bits; parameters exceeding 65535 per dimension are unsupported.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force: state IDLE, counters 0, in_ready=0, busy=0, done=0, want_write_weights=0, want_write_act=0, write_data=0, all indices=0.
REQ-027 rst_n asserted mid-load SHALL abort the load; no write strobe issues after deassertion until a new start.
REQ-028 Outputs SHALL leave reset values only on the first rising clk edge after rst_n deasserts.

Verification
REQ-029 Defaults, start, continuous in_valid, words 1..34 -> 9 weight writes (idx [0][0][0][0]..[0][0][2][2], data 1..9), then 25 act writes ([0][0][0][0]..[0][0][4][4], data 10..34), done one cycle with last write, busy 0 next.
REQ-030 NUM_INPUTS=2, NUM_OUTPUTS=2, KERNEL_DIM=2 -> 16 weight writes; 5th write idx [0][1][0][0]; 9th write idx [1][0][0][0].
REQ-031 in_valid toggling 1,0,1,0 -> write strobes only on cycles after valid transfers; indices hold between; total writes still 34.
REQ-032 rst_n pulsed low after weight word 5 -> all outputs 0 immediately; restart -> first write idx [0][0][0][0] weights.
REQ-033 start held high during load and in FINISH -> no re-trigger until IDLE; start in IDLE restarts full sequence.
REQ-034 in_valid=1 while IDLE -> in_ready=0, no writes, counters unchanged.

Source files
------------

// File: rtl/layer_load_sequencer.sv
// Streams one conv layer's weights and then its activations from a valid/ready
// input into addressed write strobes.
`timescale 1ns/1ps

module layer_load_sequencer #(
    parameter int NUM_INPUTS  = 1,
    parameter int NUM_OUTPUTS = 1,
    parameter int INPUT_DIM   = 5,
    parameter int KERNEL_DIM  = 3,
    parameter int DATA_SIZE   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 want_write_weights,
    output logic                 want_write_act,
    output logic [DATA_SIZE-1:0] write_data,
    output logic [15:0]          in_index3,
    output logic [15:0]          in_index2,
    output logic [15:0]          in_index1,
    output logic [15:0]          in_index0,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_A, FINISH} state_t;

    localparam logic [15:0] KD_MAX = 16'(KERNEL_DIM - 1);
    localparam logic [15:0] ID_MAX = 16'(INPUT_DIM - 1);
    localparam logic [15:0] NI_MAX = 16'(NUM_INPUTS - 1);
    localparam logic [15:0] NO_MAX = 16'(NUM_OUTPUTS - 1);

    state_t      state;
    logic [15:0] cnt0, cnt1, cnt2, cnt3;
    logic [15:0] lim0, lim1, lim2, lim3;
    logic        wrap0, wrap1, wrap2, wrap3;
    logic        last_word;
    logic        transfer;

    function automatic logic [15:0] step(input logic [15:0] cnt,
                                         input logic [15:0] lim,
                                         input logic        carry);
        if (!carry)
            return cnt;
        return (cnt == lim) ? 16'd0 : cnt + 16'd1;
    endfunction

    // Weight phase nests kx/ky/out/in; activation phase nests x/y/entry.
    always_comb begin
        lim0 = KD_MAX;
        lim1 = KD_MAX;
        lim2 = NO_MAX;
        lim3 = NI_MAX;
        if (state == LOAD_A) begin
            lim0 = ID_MAX;
            lim1 = ID_MAX;
            lim2 = NI_MAX;
            lim3 = 16'd0;
        end
    end

    assign wrap0     = (cnt0 == lim0);
    assign wrap1     = (cnt1 == lim1);
    assign wrap2     = (cnt2 == lim2);
    assign wrap3     = (cnt3 == lim3);
    assign last_word = wrap0 && wrap1 && wrap2 && wrap3;
    assign transfer  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt0               <= '0;
            cnt1               <= '0;
            cnt2               <= '0;
            cnt3               <= '0;
            in_ready           <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            want_write_weights <= 1'b0;
            want_write_act     <= 1'b0;
            write_data         <= '0;
            in_index3          <= '0;
            in_index2          <= '0;
            in_index1          <= '0;
            in_index0          <= '0;
        end else begin
            want_write_weights <= 1'b0;
            want_write_act     <= 1'b0;
            done               <= 1'b0;

            // The last word has every counter at its limit, so the carry chain
            // returns all counters to zero exactly at the phase change.
            if (transfer) begin
                cnt0 <= step(cnt0, lim0, 1'b1);
                cnt1 <= step(cnt1, lim1, wrap0);
                cnt2 <= step(cnt2, lim2, wrap0 && wrap1);
                cnt3 <= step(cnt3, lim3, wrap0 && wrap1 && wrap2);
                write_data <= in_data;
                in_index2  <= cnt2;
                in_index1  <= cnt1;
                in_index0  <= cnt0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD_W;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (transfer) begin
                        want_write_weights <= 1'b1;
                        in_index3          <= cnt3;
                        if (last_word)
                            state <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (transfer) begin
                        want_write_act <= 1'b1;
                        in_index3      <= 16'd0;
                        if (last_word) begin
                            state    <= FINISH;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
